// File: rtl/rot_tile_buffer_pkg.sv
// Shared definitions for the rotate tile buffer and the rotate address generator.
package rot_tile_buffer_pkg;

  localparam int unsigned DATA_W     = 24;
  localparam int unsigned TILE_DIM   = 8;
  localparam int unsigned TILE_PIX   = TILE_DIM * TILE_DIM;
  localparam int unsigned IDX_W      = $clog2(TILE_DIM);
  localparam int unsigned CNT_W      = $clog2(TILE_PIX);
  localparam int unsigned TILE_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Rotation codes, expressed as clockwise quarter turns.
  typedef enum logic [1:0] {
    DEG_0   = 2'd0,
    DEG_90  = 2'd1,
    DEG_180 = 2'd2,
    DEG_270 = 2'd3
  } rot_e;

  // Counter-clockwise turns fold into the equivalent clockwise turn; codes 4-7 mean 0 deg.
  function automatic rot_e eff_rot(input logic dir, input logic [2:0] deg);
    logic [1:0] d;
    d = deg[2] ? 2'd0 : deg[1:0];
    return dir ? rot_e'(d) : rot_e'(2'd0 - d);
  endfunction

endpackage

// File: rtl/rot_index_map.sv
// Maps an output (row, col) of the rotated tile to its raster source index.
module rot_index_map
  import rot_tile_buffer_pkg::*;
(
  input  logic [1:0]       i_rot,
  input  logic [IDX_W-1:0] i_row,
  input  logic [IDX_W-1:0] i_col,
  output logic [CNT_W-1:0] o_src_c
);

  // 7-x on a 3-bit index is a bitwise inversion, so every case is pure wiring.
  always_comb begin
    o_src_c = {i_row, i_col};
    case (i_rot)
      DEG_0:   o_src_c = {i_row, i_col};
      DEG_90:  o_src_c = {~i_col, i_row};
      DEG_180: o_src_c = {~i_row, ~i_col};
      DEG_270: o_src_c = {i_col, ~i_row};
      default: o_src_c = {i_row, i_col};
    endcase
  end

endmodule

// File: rtl/rot_tile_buffer.sv
// 8x8 pixel tile buffer: fills in raster order, drains in rotated order, repeats per tile.
module rot_tile_buffer
  import rot_tile_buffer_pkg::*;
(
  input  logic              I_HCLK,
  input  logic              I_HRESET,
  input  logic              I_START,
  input  logic              I_DIRECTION,
  input  logic [2:0]        I_DEGREES,
  input  logic [15:0]       I_TILES,
  input  logic [DATA_W-1:0] I_RDATA,
  input  logic              I_RVALID,
  output logic              O_RREADY,
  output logic [DATA_W-1:0] O_WDATA,
  output logic              O_WVALID,
  input  logic              I_WREADY,
  output logic              O_BUSY,
  output logic [5:0]        O_COUNT,
  output logic              O_DONE,
  output logic              O_ERR
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TILE_PIX - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TILE_CNT_W-1:0]   tile_cnt_q, tile_cnt_d;
  logic [TILE_CNT_W-1:0]   tiles_q, tiles_d;
  logic [1:0]              rot_q, rot_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    wvalid_q, wvalid_d;
  logic                    rready_q, rready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [DATA_W-1:0]       mem_q [TILE_PIX];
  logic                    mem_we_c;
  logic [CNT_W-1:0]        map_idx_c;
  logic [CNT_W-1:0]        src_c;

  // Index of the next pixel to present: 0 when entering the drain, cnt+1 during it.
  assign map_idx_c = (state_q == ST_DRAIN) ? cnt_q + CNT_W'(1) : '0;

  rot_index_map u_index_map (
    .i_rot   (rot_q),
    .i_row   (map_idx_c[CNT_W-1:IDX_W]),
    .i_col   (map_idx_c[IDX_W-1:0]),
    .o_src_c (src_c)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tile_cnt_d = tile_cnt_q;
    tiles_d    = tiles_q;
    rot_d      = rot_q;
    wdata_d    = wdata_q;
    wvalid_d   = wvalid_q;
    rready_d   = rready_q;
    done_d     = 1'b0;
    err_d      = err_q;
    mem_we_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          state_d    = ST_FILL;
          rot_d      = eff_rot(I_DIRECTION, I_DEGREES);
          tiles_d    = (I_TILES == '0) ? TILE_CNT_W'(1) : I_TILES;
          cnt_d      = '0;
          tile_cnt_d = '0;
          err_d      = 1'b0;
          rready_d   = 1'b1;
        end
      end

      ST_FILL: begin
        if (I_RVALID) begin
          mem_we_c = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_PIX) begin
            state_d  = ST_DRAIN;
            rready_d = 1'b0;
            wvalid_d = 1'b1;
            // The last pixel lands in mem on this edge; forward it if it is the first out.
            wdata_d  = (src_c == LAST_PIX) ? I_RDATA : mem_q[src_c];
          end
        end
      end

      ST_DRAIN: begin
        if (I_RVALID) begin
          err_d = 1'b1;
        end
        if (wvalid_q && I_WREADY) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_PIX) begin
            tile_cnt_d = tile_cnt_q + TILE_CNT_W'(1);
            wvalid_d   = 1'b0;
            if (tile_cnt_d == tiles_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_FILL;
              rready_d = 1'b1;
            end
          end else begin
            wdata_d = mem_q[src_c];
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        wvalid_d = 1'b0;
        rready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tile_cnt_q <= '0;
      tiles_q    <= TILE_CNT_W'(1);
      rot_q      <= DEG_0;
      wdata_q    <= '0;
      wvalid_q   <= 1'b0;
      rready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tile_cnt_q <= tile_cnt_d;
      tiles_q    <= tiles_d;
      rot_q      <= rot_d;
      wdata_q    <= wdata_d;
      wvalid_q   <= wvalid_d;
      rready_q   <= rready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Tile storage; contents are meaningless after reset so it carries none.
  always_ff @(posedge I_HCLK) begin
    if (mem_we_c) begin
      mem_q[cnt_q] <= I_RDATA;
    end
  end

  assign O_RREADY = rready_q;
  assign O_WDATA  = wdata_q;
  assign O_WVALID = wvalid_q;
  assign O_BUSY   = busy_q;
  assign O_COUNT  = cnt_q;
  assign O_DONE   = done_q;
  assign O_ERR    = err_q;

endmodule

// File: tb/tb_rot_tile_buffer.sv
// Randomized bench for rot_tile_buffer against a matrix-rotation reference model.
module tb_rot_tile_buffer;

  logic        I_HCLK = 1'b0;
  logic        I_HRESET;
  logic        I_START;
  logic        I_DIRECTION;
  logic [2:0]  I_DEGREES;
  logic [15:0] I_TILES;
  logic [23:0] I_RDATA;
  logic        I_RVALID;
  logic        O_RREADY;
  logic [23:0] O_WDATA;
  logic        O_WVALID;
  logic        I_WREADY;
  logic        O_BUSY;
  logic [5:0]  O_COUNT;
  logic        O_DONE;
  logic        O_ERR;

  rot_tile_buffer dut (
    .I_HCLK      (I_HCLK),
    .I_HRESET    (I_HRESET),
    .I_START     (I_START),
    .I_DIRECTION (I_DIRECTION),
    .I_DEGREES   (I_DEGREES),
    .I_TILES     (I_TILES),
    .I_RDATA     (I_RDATA),
    .I_RVALID    (I_RVALID),
    .O_RREADY    (O_RREADY),
    .O_WDATA     (O_WDATA),
    .O_WVALID    (O_WVALID),
    .I_WREADY    (I_WREADY),
    .O_BUSY      (O_BUSY),
    .O_COUNT     (O_COUNT),
    .O_DONE      (O_DONE),
    .O_ERR       (O_ERR)
  );

  always #5 I_HCLK = ~I_HCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  logic [23:0] pix  [64];
  logic [23:0] expq [64];
  logic [23:0] first_out, last_out;

  always @(posedge I_HCLK) if (O_DONE === 1'b1) done_seen <= done_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_HCLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rready"}, 32'(O_RREADY), 0);
    check({tag, "_wdata"},  32'(O_WDATA), 0);
    check({tag, "_wvalid"}, 32'(O_WVALID), 0);
    check({tag, "_busy"},   32'(O_BUSY), 0);
    check({tag, "_count"},  32'(O_COUNT), 0);
    check({tag, "_done"},   32'(O_DONE), 0);
    check({tag, "_err"},    32'(O_ERR), 0);
  endtask

  // Reference: rotate the 8x8 matrix clockwise one quarter turn at a time.
  task automatic compute_expected(input int rot);
    logic [23:0] m [8][8];
    logic [23:0] t [8][8];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = pix[r*8 + c];
    for (int n = 0; n < rot; n++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          t[r][c] = m[7-c][r];
      m = t;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        expq[r*8 + c] = m[r][c];
  endtask

  task automatic run_frame(input logic dir, input logic [2:0] deg, input logic [15:0] tiles,
                           input bit rnd_pix, input bit rnd_ready, input int err_at,
                           input int rst_at, input bit start_busy);
    int d, rot, n_tiles, i, k, g, done_before;
    bit acc, held;
    logic [23:0] held_data;
    d       = (deg > 3) ? 0 : int'(deg);
    rot     = dir ? d : (4 - d) % 4;
    n_tiles = (tiles == 0) ? 1 : int'(tiles);
    done_before = done_seen;

    I_DIRECTION = dir; I_DEGREES = deg; I_TILES = tiles; I_START = 1'b1;
    tick();
    I_START = 1'b0;
    I_DIRECTION = ~dir; I_DEGREES = 3'($urandom); I_TILES = 16'($urandom_range(2, 9));
    check("start_busy",   32'(O_BUSY), 1);
    check("start_rready", 32'(O_RREADY), 1);
    check("start_count",  32'(O_COUNT), 0);
    check("start_err",    32'(O_ERR), 0);

    for (int t = 0; t < n_tiles; t++) begin
      for (int p = 0; p < 64; p++) pix[p] = rnd_pix ? 24'($urandom) : 24'(p);
      compute_expected(rot);

      i = 0; g = 0;
      while (i < 64 && g < 500) begin
        I_RVALID = rnd_pix ? ($urandom_range(0, 3) != 0) : 1'b1;
        I_RDATA  = pix[i];
        I_START  = start_busy && t == 0 && i == 5;
        if (I_START) I_DEGREES = 3'($urandom);
        acc = I_RVALID && O_RREADY;
        tick();
        if (acc) i++;
        g++;
      end
      I_RVALID = 1'b0; I_START = 1'b0;
      if (i < 64) check("fill_timeout", 32'(i), 64);
      check("fill_end_rready", 32'(O_RREADY), 0);
      check("fill_end_wvalid", 32'(O_WVALID), 1);

      k = 0; g = 0; held = 1'b0;
      while (k < 64 && g < 2000) begin
        if (t == 0 && k == rst_at) begin
          I_HRESET = 1'b1;
          tick();
          I_HRESET = 1'b0;
          check_reset_outputs("mid_reset");
          return;
        end
        if (held) check("wdata_hold", 32'(O_WDATA), 32'(held_data));
        check("drain_wvalid", 32'(O_WVALID), 1);
        I_WREADY = rnd_ready ? 1'($urandom) : 1'b1;
        I_RVALID = (t == 0 && k == err_at && g == 0) || (t == 0 && k == err_at && !held);
        if (O_WVALID && I_WREADY) begin
          check("pixel", 32'(O_WDATA), 32'(expq[k]));
          if (t == 0 && k == 0) first_out = O_WDATA;
          if (t == n_tiles - 1 && k == 63) last_out = O_WDATA;
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_data = O_WDATA;
        end
        tick();
        I_RVALID = 1'b0;
        g++;
      end
      if (k < 64) check("drain_timeout", 32'(k), 64);
      if (t == 0 && err_at >= 0) check("err_sticky", 32'(O_ERR), 1);

      if (t == n_tiles - 1) begin
        check("end_done",   32'(O_DONE), 1);
        check("end_busy",   32'(O_BUSY), 0);
        check("end_wvalid", 32'(O_WVALID), 0);
        check("end_rready", 32'(O_RREADY), 0);
        tick();
        check("done_pulse", 32'(O_DONE), 0);
      end else begin
        check("refill_wvalid", 32'(O_WVALID), 0);
        check("refill_rready", 32'(O_RREADY), 1);
        check("refill_count",  32'(O_COUNT), 0);
        check("refill_done",   32'(O_DONE), 0);
      end
    end
    check("done_count", 32'(done_seen - done_before), 1);
  endtask

  initial begin
    I_HRESET = 1'b1; I_START = 1'b0; I_DIRECTION = 1'b0; I_DEGREES = '0; I_TILES = '0;
    I_RDATA = '0; I_RVALID = 1'b0; I_WREADY = 1'b0;
    repeat (3) tick();
    I_HRESET = 1'b0;
    check_reset_outputs("reset");
    tick();

    run_frame(1'b1, 3'd0, 16'd1, 1'b0, 1'b0, -1, -1, 1'b0);
    check("deg0_first", 32'(first_out), 0);
    check("deg0_last",  32'(last_out), 63);

    run_frame(1'b1, 3'd1, 16'd1, 1'b0, 1'b0, -1, -1, 1'b0);
    check("cw90_first", 32'(first_out), 56);
    check("cw90_last",  32'(last_out), 7);

    run_frame(1'b0, 3'd1, 16'd1, 1'b0, 1'b0, -1, -1, 1'b0);
    check("ccw90_first", 32'(first_out), 7);
    check("ccw90_last",  32'(last_out), 56);

    run_frame(1'b1, 3'd3, 16'd1, 1'b0, 1'b0, -1, -1, 1'b0);
    check("cw270_first", 32'(first_out), 7);
    check("cw270_last",  32'(last_out), 56);

    run_frame(1'b1, 3'd2, 16'd3, 1'b1, 1'b1, -1, -1, 1'b1);

    run_frame(1'b1, 3'd0, 16'd2, 1'b1, 1'b1, 10, -1, 1'b0);

    run_frame(1'b0, 3'd2, 16'd1, 1'b1, 1'b1, -1, 20, 1'b0);
    tick();

    run_frame(1'b1, 3'd5, 16'd0, 1'b0, 1'b0, -1, -1, 1'b0);
    check("deg5_first", 32'(first_out), 0);
    check("deg5_last",  32'(last_out), 63);

    run_frame(1'b0, 3'd3, 16'd2, 1'b1, 1'b1, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rot_tile_buffer.md
# rot_tile_buffer

8×8 pixel tile buffer sitting directly downstream of the rotate address generator's read phase and upstream of its write phase. It captures one 64-pixel tile (24-bit RGB, one pixel per beat) in raster order during the read phase. It then re-emits the tile in rotated order so that the write-phase addresses receive correctly transposed data. It loops fill/drain for a programmed number of tiles per frame.

## Interface
- DATA_W, 24, pixel width in bits (3 bytes/pixel)
- I_HCLK  in  1  clock
- I_HRESET  in  1  reset; synchronous, active-high
- I_START  in  1  one-cycle pulse; latches config, begins frame; ignored while O_BUSY=1
- I_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise
- I_DEGREES  in  3  0=0°, 1=90°, 2=180°, 3=270°; 4–7 treated as 0°
- I_TILES  in  16  tiles in frame; 0 treated as 1
- I_RDATA  in  DATA_W  read-phase pixel
- I_RVALID  in  1  I_RDATA valid
- O_RREADY  out  1  buffer accepts pixel (FILL state)
- O_WDATA  out  DATA_W  rotated pixel, registered
- O_WVALID  out  1  O_WDATA valid
- I_WREADY  in  1  downstream accepts O_WDATA
- O_BUSY  out  1  state ≠ IDLE
- O_COUNT  out  6  pixels accepted (FILL) or emitted (DRAIN) in current tile
- O_DONE  out  1  one-cycle pulse after last pixel of last tile
- O_ERR  out  1  sticky: I_RVALID seen outside FILL while busy; cleared by I_START

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE → FILL on I_START. Latch rotation code and tile count. Clear O_COUNT, tile counter and O_ERR.
- FILL:
  - O_RREADY=1.
  - Each I_RVALID beat writes mem[cnt], with cnt = row*8+col, and increments cnt.
  - On the 64th beat (cnt==63 accepted): FILL → DRAIN, cnt←0.
- DRAIN:
  - Output index k = r*8+c is read from source index s(r,c).
  - Effective rotation: rot = I_DIRECTION ? deg : (4−deg) mod 4.
  - rot 0: s=(r,c). rot 1 (90° CW): s=(7−c, r). rot 2: s=(7−r, 7−c). rot 3 (270° CW): s=(c, 7−r).
  - Index arithmetic is pure 3-bit bit-manipulation; no multipliers.
  - A pixel transfers when O_WVALID && I_WREADY. Then cnt increments and O_WDATA reloads with the next pixel in the same cycle.
  - After pixel 63 transfers: tile counter increments.
    - If the counter equals the latched I_TILES: DRAIN → IDLE and O_DONE pulses.
    - Otherwise DRAIN → FILL and cnt←0.
- I_RVALID outside FILL while busy: data dropped, O_ERR←1.
- I_START while busy: ignored; config unchanged.
- Reset mid-operation: return to IDLE on the next edge. Buffer contents are don't-care.
- Reset values: O_RREADY=0, O_WDATA=0, O_WVALID=0, O_BUSY=0, O_COUNT=0, O_DONE=0, O_ERR=0.

## Timing
- Storage is a 64×DATA_W register array with asynchronous read. O_WDATA is a register.
- FILL entry: O_RREADY=1 in the cycle after the I_START edge.
- FILL → DRAIN:
  - O_RREADY drops in the cycle after the 64th accepted beat.
  - In that same cycle, O_WVALID=1 and O_WDATA=pixel s(0,0).
- O_WVALID and O_WDATA hold stable while I_WREADY=0.
- With I_WREADY held high, throughput is 1 pixel/cycle. The drain takes 64 cycles.
- DRAIN → FILL: O_WVALID=0 and O_RREADY=1 in the cycle after the last transfer. There is no bubble beyond that cycle.
- O_DONE is asserted in the same cycle O_BUSY falls.
- Tile counter is 16-bit; comparison is equality against the latched I_TILES (0 is stored as 1).

## Structure
- Shared package holds:
  - State encodings IDLE/FILL/DRAIN.
  - Rotation codes DEG_0..DEG_270.
  - TILE_DIM=8 and TILE_PIX=64.
  - The direction/degree → effective-rotation function, which the address generator also uses.
- Sub-module rot_index_map: combinational (rot, r, c) → source index. Instantiated once, driven by the drain counter's next value.

## Test plan
- Reset, then I_START with dir=1, deg=0, tiles=1; feed pixels 0..63 with I_WREADY=1 → output is 0..63 in order, O_DONE pulses once, O_BUSY=0.
- dir=1, deg=1, pixels=index → first outputs 56, 48, 40; output 7 = 0; last output = 7.
- dir=0, deg=1 (CCW 90°) → outputs 7, 15, 23 …; last output = 56. dir=1, deg=3 must produce an identical stream.
- dir=1, deg=2, tiles=3, random I_WREADY toggling → each tile emits 63..0, O_WDATA stable while stalled, exactly 192 transfers, one O_DONE.
- I_RVALID pulse during DRAIN → O_ERR=1, drain output unchanged; next I_START clears O_ERR.
- Assert I_HRESET at drain pixel 20 → all outputs return to reset values next cycle; a fresh I_START, deg=5 → behaves as 0°.
